// File: rtl/half_adder.sv
// Registered multi-lane half adder with an any-carry flag and a saturating
// count of accepted samples. Each lane is independent; there is no cross-lane
// carry. Every output comes straight from a flop.
module half_adder #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic             any_carry,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] sum_q,   sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             any_q,   any_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next state: compute on accepted samples, otherwise hold. Operands are only
  // looked at when in_valid is high, so unknowns on idle cycles never reach a flop.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    any_d   = any_q;
    cnt_d   = cnt_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = a ^ b;
      carry_d = a & b;
      any_d   = |(a & b);
      // Counter sticks at all-ones rather than wrapping.
      cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset wins over an accepted sample on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      any_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      any_q   <= any_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign c          = sum_q;
  assign d          = carry_q;
  assign any_carry  = any_q;
  assign out_valid  = valid_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder (WIDTH=8, CNT_W=3). Stimulus pushes the
// expected response of every accepted sample; a negedge monitor pops on
// out_valid and otherwise checks that outputs hold (or read zero after reset).
module tb_half_adder;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [W-1:0]  c;
    logic [W-1:0]  d;
    logic          any;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  c, d;
  logic          out_valid, any_carry;
  logic [CW-1:0] sample_cnt;

  exp_t exp_q[$];
  exp_t held = '0;
  logic ov_exp = 1'b0;
  logic rst_q  = 1'b0;
  logic armed  = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [CW-1:0] model_cnt;

  half_adder #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .any_carry (any_carry),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [15:0] act,
                                input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endfunction

  // Reference for out_valid timing and for which edges were resets.
  always @(posedge clk) begin
    ov_exp <= in_valid & ~rst;
    rst_q  <= rst;
    armed  <= armed | rst;
  end

  // Monitor: pop on valid output, otherwise expect held (or reset) values.
  always @(negedge clk) begin
    if (armed) begin
      if (rst_q) held = '0;
      check("out_valid", 16'(out_valid), 16'(ov_exp));
      if (ov_exp) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty at %0t: got empty queue, required an entry", $time);
        end else begin
          held = exp_q.pop_front();
        end
      end
      check("c", 16'(c), 16'(held.c));
      check("d", 16'(d), 16'(held.d));
      check("any_carry", 16'(any_carry), 16'(held.any));
      check("sample_cnt", 16'(sample_cnt), 16'(held.cnt));
    end
  end

  // One cycle of stimulus, driven 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic [W-1:0] av,
                     input logic [W-1:0] bv);
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
  endtask

  // Accepted sample with its hand-computed expected response.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] ec, input logic [W-1:0] ed,
                      input logic eany, input logic [CW-1:0] ecnt);
    cyc(1'b0, 1'b1, av, bv);
    exp_q.push_back('{c: ec, d: ed, any: eany, cnt: ecnt});
  endtask

  initial begin
    cyc(1'b1, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b0, 8'h00, 8'h00);

    // Truth-table sweep on lane 0.
    send(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1);
    send(8'h00, 8'h01, 8'h01, 8'h00, 1'b0, 3'd2);
    send(8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 3'd3);
    send(8'h01, 8'h01, 8'h00, 8'h01, 1'b1, 3'd4);

    // Idle cycles: outputs hold c=0, d=1, cnt=4 with out_valid low.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset together with a valid sample: sample dropped, not counted.
    cyc(1'b1, 1'b1, 8'h01, 8'h01);
    send(8'h00, 8'h01, 8'h01, 8'h00, 1'b0, 3'd1);

    // Multi-lane vectors on the low nibble.
    send(8'h0C, 8'h0A, 8'h06, 8'h08, 1'b1, 3'd2);
    send(8'h05, 8'h0A, 8'h0F, 8'h00, 1'b0, 3'd3);
    cyc(1'b0, 1'b0, 8'h00, 8'h00);

    // Saturation: ten back-to-back samples, count reads 1..7 then stays at 7.
    cyc(1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      send(8'hF0, 8'h3C, 8'hCC, 8'h30, 1'b1, (i < 7) ? CW'(i + 1) : 3'd7);
    end
    cyc(1'b0, 1'b0, 8'h00, 8'h00);

    // Random traffic; idle-cycle operands are random and must be ignored.
    cyc(1'b1, 1'b0, 8'h00, 8'h00);
    model_cnt = '0;
    for (int i = 0; i < 1000; i++) begin
      logic          v;
      logic [W-1:0] ra, rb;
      v  = ($urandom_range(0, 3) != 0);
      ra = W'($urandom);
      rb = W'($urandom);
      if (v) begin
        if (model_cnt != 3'd7) model_cnt = model_cnt + 3'd1;
        send(ra, rb, ra ^ rb, ra & rb, |(ra & rb), model_cnt);
      end else begin
        cyc(1'b0, 1'b0, ra, rb);
      end
    end

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/half_adder.md
# half_adder

Registered, multi-lane half adder. Each cycle with `in_valid` high, every lane `i` adds `a[i]` and `b[i]` and registers the sum bit on `c[i]` and the carry bit on `d[i]`. The block also reports an any-carry flag and a saturating count of accepted samples. It is the base arithmetic cell for ripple and carry-save adders, and it is the smoke-test target for the datapath bench.

## Interface
- `WIDTH`, default 1: number of independent half-adder lanes (≥1).
- `CNT_W`, default 16: width of the accepted-sample counter (≥1).

Ports (name, direction, width, meaning):
- `clk`, input, 1: the block's single clock. Everything is sampled on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `a`/`b` are valid this cycle and are accepted.
- `a`, input, WIDTH: addend A, one bit per lane.
- `b`, input, WIDTH: addend B, one bit per lane.
- `c`, output, WIDTH: registered sum bits, `a ^ b` per lane.
- `d`, output, WIDTH: registered carry bits, `a & b` per lane.
- `out_valid`, output, 1: `c`/`d` were updated by the previous edge.
- `any_carry`, output, 1: registered OR-reduction of the carry bits of the last accepted sample.
- `sample_cnt`, output, CNT_W: number of accepted samples since reset, saturating.

## Operation
- Per lane `i`, on an accepted sample: `c[i] <= a[i] ^ b[i]` and `d[i] <= a[i] & b[i]`. There is no cross-lane carry.
- Truth table per lane (a,b → c,d):
  - 0,0 → 0,0
  - 0,1 → 1,0
  - 1,0 → 1,0
  - 1,1 → 0,1
- Identity: `2*d[i] + c[i] == a[i] + b[i]` for every lane and every accepted sample.
- `any_carry <= |(a & b)` on an accepted sample.
- `sample_cnt` increments by 1 on each accepted sample and holds at all-ones (2^CNT_W − 1). It never wraps.
- When `in_valid` is low:
  - `c`, `d` and `any_carry` hold their previous values.
  - `sample_cnt` holds.
  - `out_valid` goes to 0.
- `a` and `b` are ignored when `in_valid` is low. X on ignored inputs must not propagate.
- There is no backpressure. Every `in_valid` cycle is accepted.

## Timing
- Latency is exactly 1 cycle: inputs at edge N appear on `c`/`d`/`any_carry` after edge N, with `out_valid` = 1 during that same cycle.
- `out_valid` follows `in_valid` delayed by one cycle. It stays high for back-to-back samples, giving a throughput of 1 sample per cycle.
- Reset values: `c` = 0, `d` = 0, `any_carry` = 0, `out_valid` = 0, `sample_cnt` = 0.
- Reset takes priority over `in_valid` on the same edge. That sample is discarded and not counted.
- If reset is asserted mid-stream, all outputs return to reset values on the next edge. The first `in_valid` after `rst` deasserts is treated as sample 1.
- All outputs are driven directly from flops, with no combinational path from any input to any output.

## Test plan
- Exhaustive sweep with WIDTH=1: after reset, apply (a,b) = (0,0), (0,1), (1,0), (1,1) on consecutive `in_valid` cycles.
  - Required (c,d) one cycle later: (0,0), (1,0), (1,0), (0,1).
  - Required `any_carry`: 0,0,0,1.
  - Required `sample_cnt`: 1..4.
- Multi-lane with WIDTH=4: a=4'b1100, b=4'b1010 → c=4'b0110, d=4'b1000, `any_carry`=1. Then a=4'b0101, b=4'b1010 → c=4'b1111, d=4'b0000, `any_carry`=0.
- Hold with `in_valid` low: after the sample (1,1), drive `in_valid`=0 with a=0, b=0 for 3 cycles.
  - c=0, d=1 and `sample_cnt` must be unchanged.
  - `out_valid` must be 0 for those cycles.
- Reset priority: assert `rst` and `in_valid` together with a=1, b=1.
  - Next cycle: all outputs are 0 and `sample_cnt`=0.
  - After `rst` drops, a=0, b=1 → c=1, d=0, `sample_cnt`=1.
- Saturation with CNT_W=3: apply 10 back-to-back valid samples. `sample_cnt` must read 1..7 and then stay at 7.
- Random check: random a/b/`in_valid` for 1000 cycles with WIDTH=8. The identity `2*d+c == a+b` per lane must hold, and `out_valid` must equal `in_valid` delayed by one cycle.
